// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder
// Receive side of a multiplexed 7-segment bus. Synchronises the active-low
// segment and anode lines, waits for each anode dwell to settle, decodes the
// digit shown on the driven position into a shadow frame, and publishes the
// whole frame atomically once every position has been captured.
module seg_scan_decoder #(
  parameter int NDIG       = 4,
  parameter int STABLE_CYC = 8,
  parameter int TIMEOUT    = 1048576
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          seg_in,
  input  logic [NDIG-1:0]     an_in,
  output logic [4*NDIG-1:0]   digits_out,
  output logic [NDIG-1:0]     dots_out,
  output logic [NDIG-1:0]     err_out,
  output logic                frame_valid,
  output logic                stale
);

  localparam int CW = $clog2(STABLE_CYC + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYC - 1);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO    = CW'(0);
  localparam logic [TW-1:0] TMAX        = TW'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_HOLD   = 2'd2
  } state_t;

  // Segment pattern (g..a, active low) to {err, digit}.
  function automatic logic [4:0] f_decode(input logic [6:0] pat);
    case (pat)
      7'b1000000: f_decode = {1'b0, 4'h0};
      7'b1111001: f_decode = {1'b0, 4'h1};
      7'b0100100: f_decode = {1'b0, 4'h2};
      7'b0110000: f_decode = {1'b0, 4'h3};
      7'b0011001: f_decode = {1'b0, 4'h4};
      7'b0010010: f_decode = {1'b0, 4'h5};
      7'b0000010: f_decode = {1'b0, 4'h6};
      7'b1111000: f_decode = {1'b0, 4'h7};
      7'b0000000: f_decode = {1'b0, 4'h8};
      7'b0010000: f_decode = {1'b0, 4'h9};
      7'b1111111: f_decode = {1'b0, 4'hF};
      default:    f_decode = {1'b1, 4'hE};
    endcase
  endfunction

  // True when exactly one anode line is pulled low.
  function automatic logic f_onehot_low(input logic [NDIG-1:0] an);
    logic [3:0] v_zeros;
    v_zeros = 4'd0;
    for (int i = 0; i < NDIG; i++) begin
      if (!an[i]) begin
        v_zeros = v_zeros + 4'd1;
      end else begin
        v_zeros = v_zeros;
      end
    end
    return (v_zeros == 4'd1);
  endfunction

  logic [7:0]        r_seg_m, r_seg_s, r_seg_p;
  logic [NDIG-1:0]   r_an_m, r_an_s, r_an_p;
  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic [4*NDIG-1:0] r_sh_dig;
  logic [NDIG-1:0]   r_sh_dot;
  logic [NDIG-1:0]   r_sh_err;
  logic [NDIG-1:0]   r_mask;
  logic [4*NDIG-1:0] r_digits;
  logic [NDIG-1:0]   r_dots;
  logic [NDIG-1:0]   r_err;
  logic              r_frame_valid;
  logic [TW-1:0]     r_stale_cnt;
  logic              r_stale;

  logic              w_an_ok;
  logic              w_an_chg;
  logic              w_same;
  logic              w_capture;
  logic              w_mask_full;
  logic [4:0]        w_dec;
  logic [NDIG-1:0]   w_cap_sel;

  assign w_an_ok     = f_onehot_low(r_an_s);
  assign w_an_chg    = (r_an_s != r_an_p);
  assign w_same      = (r_an_s == r_an_p) && (r_seg_s == r_seg_p);
  assign w_capture   = (r_state == S_SETTLE) && w_same && (r_cnt == STABLE_LAST);
  assign w_mask_full = &r_mask;
  assign w_dec       = f_decode(r_seg_s[6:0]);

  // Slot select for the capture happening this cycle (the low anode bit).
  always_comb begin
    w_cap_sel = {NDIG{1'b0}};
    if (w_capture) begin
      w_cap_sel = ~r_an_s;
    end else begin
      w_cap_sel = {NDIG{1'b0}};
    end
  end

  // Two-flop synchronisers plus the previous synced sample for change detect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seg_m <= 8'hFF;
      r_seg_s <= 8'hFF;
      r_seg_p <= 8'hFF;
      r_an_m  <= {NDIG{1'b1}};
      r_an_s  <= {NDIG{1'b1}};
      r_an_p  <= {NDIG{1'b1}};
    end else begin
      r_seg_m <= seg_in;
      r_seg_s <= r_seg_m;
      r_seg_p <= r_seg_s;
      r_an_m  <= an_in;
      r_an_s  <= r_an_m;
      r_an_p  <= r_an_s;
    end
  end

  // Dwell tracker: settle on a one-hot anode, capture once, then hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= CNT_ZERO;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_an_ok) begin
            r_state <= S_SETTLE;
            r_cnt   <= CNT_ONE;
          end else begin
            r_state <= S_IDLE;
            r_cnt   <= CNT_ZERO;
          end
        end
        S_SETTLE: begin
          if (w_same) begin
            if (r_cnt == STABLE_LAST) begin
              r_state <= S_HOLD;
              r_cnt   <= CNT_ZERO;
            end else begin
              r_cnt   <= r_cnt + CNT_ONE;
            end
          end else if (w_an_ok) begin
            r_cnt   <= CNT_ONE;
          end else begin
            r_state <= S_IDLE;
            r_cnt   <= CNT_ZERO;
          end
        end
        S_HOLD: begin
          // Segment-only changes are ignored; only an anode change ends the dwell.
          if (w_an_chg) begin
            if (w_an_ok) begin
              r_state <= S_SETTLE;
              r_cnt   <= CNT_ONE;
            end else begin
              r_state <= S_IDLE;
              r_cnt   <= CNT_ZERO;
            end
          end else begin
            r_state <= S_HOLD;
            r_cnt   <= CNT_ZERO;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= CNT_ZERO;
        end
      endcase
    end
  end

  // Shadow frame: latest capture for a position overwrites its slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sh_dig <= {NDIG{4'hF}};
      r_sh_dot <= {NDIG{1'b0}};
      r_sh_err <= {NDIG{1'b0}};
    end else begin
      for (int i = 0; i < NDIG; i++) begin
        if (w_cap_sel[i]) begin
          r_sh_dig[4*i +: 4] <= w_dec[3:0];
          r_sh_dot[i]        <= ~r_seg_s[7];
          r_sh_err[i]        <= w_dec[4];
        end
      end
    end
  end

  // Frame publish: full mask copies the shadow out; a same-cycle capture seeds the next mask.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mask        <= {NDIG{1'b0}};
      r_digits      <= {NDIG{4'hF}};
      r_dots        <= {NDIG{1'b0}};
      r_err         <= {NDIG{1'b0}};
      r_frame_valid <= 1'b0;
    end else if (w_mask_full) begin
      r_mask        <= w_cap_sel;
      r_digits      <= r_sh_dig;
      r_dots        <= r_sh_dot;
      r_err         <= r_sh_err;
      r_frame_valid <= 1'b1;
    end else begin
      r_mask        <= r_mask | w_cap_sel;
      r_frame_valid <= 1'b0;
    end
  end

  // Stale timer: saturating count of cycles since the last published frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stale_cnt <= {TW{1'b0}};
      r_stale     <= 1'b0;
    end else if (w_mask_full) begin
      r_stale_cnt <= {TW{1'b0}};
      r_stale     <= 1'b0;
    end else if (r_stale_cnt == TMAX) begin
      r_stale_cnt <= r_stale_cnt;
      r_stale     <= 1'b1;
    end else begin
      r_stale_cnt <= r_stale_cnt + TW'(1);
      r_stale     <= ((r_stale_cnt + TW'(1)) == TMAX);
    end
  end

  assign digits_out  = r_digits;
  assign dots_out    = r_dots;
  assign err_out     = r_err;
  assign frame_valid = r_frame_valid;
  assign stale       = r_stale;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: scans digit patterns across the four
// positions and compares the published frame against hand-computed values.
module tb_seg_scan_decoder;

  localparam int NDIG  = 4;
  localparam int STAB  = 8;
  localparam int TOUT  = 300;
  localparam int DWELL = 32;

  // Segment bytes with dot off: {1, g..a}
  localparam logic [7:0] S0 = 8'hC0, S1 = 8'hF9, S2 = 8'hA4, S3 = 8'hB0, S4 = 8'h99;
  localparam logic [7:0] S5 = 8'h92, S6 = 8'h82, S7 = 8'hF8, S8 = 8'h80, S9 = 8'h90;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        seg_in;
  logic [NDIG-1:0]   an_in;
  logic [4*NDIG-1:0] digits_out;
  logic [NDIG-1:0]   dots_out;
  logic [NDIG-1:0]   err_out;
  logic              frame_valid;
  logic              stale;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int fv_cnt  = 0;
  int fv_cyc  = 0;
  int st_rise = 0;
  logic st_prev = 1'b0;
  int f0;
  int t0;

  seg_scan_decoder #(.NDIG(NDIG), .STABLE_CYC(STAB), .TIMEOUT(TOUT)) dut (
    .clk(clk), .rst(rst), .seg_in(seg_in), .an_in(an_in),
    .digits_out(digits_out), .dots_out(dots_out), .err_out(err_out),
    .frame_valid(frame_valid), .stale(stale)
  );

  always #5 clk = ~clk;

  // Cycle counter
  always @(posedge clk) cyc <= cyc + 1;

  // Frame pulse and stale edge monitor
  always @(negedge clk) begin
    if (frame_valid) begin
      fv_cnt <= fv_cnt + 1;
      fv_cyc <= cyc;
    end
    if (stale && !st_prev) st_rise <= cyc;
    st_prev <= stale;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int pos, input logic [7:0] seg, input int n);
    an_in  = ~(4'b0001 << pos);
    seg_in = seg;
    repeat (n) @(negedge clk);
  endtask

  task automatic idle(input int n);
    an_in  = 4'hF;
    seg_in = 8'hFF;
    repeat (n) @(negedge clk);
  endtask

  task automatic scan(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    drive(0, a, DWELL);
    drive(1, b, DWELL);
    drive(2, c, DWELL);
    drive(3, d, DWELL);
  endtask

  task automatic do_reset();
    an_in  = 4'hF;
    seg_in = 8'hFF;
    rst    = 1'b1;
    repeat (2) @(negedge clk);
    rst    = 1'b0;
    @(negedge clk);
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_fail %0d", n_fail);
    $fatal(1);
  end

  initial begin
    an_in  = 4'hF;
    seg_in = 8'hFF;
    rst    = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_digits", 32'(digits_out), 32'hFFFF);
    chk("rst_dots", 32'(dots_out), 32'h0);
    chk("rst_err", 32'(err_out), 32'h0);
    chk("rst_fv", 32'(frame_valid), 32'h0);
    chk("rst_stale", 32'(stale), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Basic scan 1,2,3,4
    f0 = fv_cnt;
    scan(S1, S2, S3, S4);
    idle(4);
    chk("scan_fv1", 32'(fv_cnt - f0), 32'd1);
    chk("scan_digits", 32'(digits_out), 32'h4321);
    chk("scan_dots", 32'(dots_out), 32'h0);
    chk("scan_err", 32'(err_out), 32'h0);
    f0 = fv_cnt;
    scan(S1, S2, S3, S4);
    scan(S1, S2, S3, S4);
    idle(4);
    chk("scan_fv2", 32'(fv_cnt - f0), 32'd2);

    // Blank position 2, dot lit on position 0
    do_reset();
    scan(S1 & 8'h7F, S2, 8'hFF, S4);
    idle(4);
    chk("blank_digits", 32'(digits_out), 32'h4F21);
    chk("blank_dots", 32'(dots_out), 32'h1);
    chk("blank_err", 32'(err_out), 32'h0);

    // Undecodable pattern on position 1
    do_reset();
    scan(S1, 8'hD5, S3, S4);
    idle(4);
    chk("bad_digits", 32'(digits_out), 32'h43E1);
    chk("bad_err", 32'(err_out), 32'h2);
    chk("bad_dots", 32'(dots_out), 32'h0);

    // Digits 0,9,8,7
    do_reset();
    scan(S0, S9, S8, S7);
    idle(4);
    chk("d0987_digits", 32'(digits_out), 32'h7890);

    // Glitching segments on position 0, then steady 6
    do_reset();
    f0 = fv_cnt;
    for (int k = 0; k < 10; k++) drive(0, (k % 2 == 1) ? S1 : S7, 3);
    drive(0, S6, DWELL);
    drive(1, S2, DWELL);
    drive(2, S3, DWELL);
    drive(3, S4, DWELL);
    idle(4);
    chk("glitch_fv", 32'(fv_cnt - f0), 32'd1);
    chk("glitch_digits", 32'(digits_out), 32'h4326);

    // Ghost anode (all low) must not capture
    do_reset();
    f0 = fv_cnt;
    drive(0, S1, DWELL);
    drive(1, S2, DWELL);
    drive(2, S3, DWELL);
    an_in  = 4'h0;
    seg_in = S8;
    repeat (40) @(negedge clk);
    chk("ghost_nofv", 32'(fv_cnt - f0), 32'd0);
    drive(3, S4, DWELL);
    idle(4);
    chk("ghost_fv", 32'(fv_cnt - f0), 32'd1);
    chk("ghost_digits", 32'(digits_out), 32'h4321);

    // Skipped position re-captured: latest wins
    do_reset();
    f0 = fv_cnt;
    drive(0, S1, DWELL);
    drive(1, S2, DWELL);
    drive(0, S5, DWELL);
    drive(2, S3, DWELL);
    drive(3, S4, DWELL);
    idle(4);
    chk("recap_fv", 32'(fv_cnt - f0), 32'd1);
    chk("recap_digits", 32'(digits_out), 32'h4325);

    // Stale after TOUT idle cycles, cleared by a resumed scan
    do_reset();
    scan(S1, S2, S3, S4);
    an_in  = 4'hF;
    seg_in = 8'hFF;
    for (int k = 0; k < 2 * TOUT; k++) begin
      if (stale) break;
      @(negedge clk);
    end
    @(negedge clk);
    chk("stale_high", 32'(stale), 32'd1);
    chk("stale_delay", 32'(st_rise - fv_cyc), 32'(TOUT));
    chk("stale_hold", 32'(digits_out), 32'h4321);
    idle(20);
    chk("stale_stays", 32'(stale), 32'd1);
    scan(S5, S6, S7, S8);
    idle(2);
    chk("stale_clear", 32'(stale), 32'd0);
    chk("resume_digits", 32'(digits_out), 32'h8765);

    // Async reset mid-dwell after 3 of 4 captured
    do_reset();
    scan(S1, S2, S3, S4);
    drive(0, S5, DWELL);
    drive(1, S6, DWELL);
    drive(2, S7, DWELL);
    drive(3, S8, 5);
    #2 rst = 1'b1;
    #1;
    chk("mrst_digits", 32'(digits_out), 32'hFFFF);
    chk("mrst_dots", 32'(dots_out), 32'h0);
    chk("mrst_err", 32'(err_out), 32'h0);
    chk("mrst_fv", 32'(frame_valid), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    f0 = fv_cnt;
    drive(3, S8, DWELL);
    chk("mrst_nofv", 32'(fv_cnt - f0), 32'd0);
    drive(0, S5, DWELL);
    drive(1, S6, DWELL);
    t0 = cyc;
    drive(2, S7, DWELL);
    idle(4);
    chk("mrst_fv1", 32'(fv_cnt - f0), 32'd1);
    chk("mrst_latency", 32'(fv_cyc - t0), 32'(STAB + 3));
    chk("mrst_digits2", 32'(digits_out), 32'h8765);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
